// File: rtl/mac_row_requant.sv
// Requantizes a serial stream of signed accumulator elements and packs them into double-buffered
// output rows. Define MAC_REQUANT_RELU_EN to clamp negative results to zero after saturation.
module mac_row_requant #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned ROW_LEN    = 16,
  parameter int unsigned NUM_ROWS   = 8
) (
  input  logic                          clk_p,
  input  logic                          rst_p,
  input  logic [4:0]                    cfg_shift,
  input  logic [ACC_WIDTH-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [ROW_LEN*DATA_WIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          sat_flag
);

  localparam int unsigned ExtW = ACC_WIDTH + 1;
  localparam int unsigned ColW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned RowW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [4:0] MaxShift = 5'(ACC_WIDTH - 1);
  localparam logic signed [ExtW-1:0] SatMax = ExtW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ExtW-1:0] SatMin = -ExtW'(2 ** (DATA_WIDTH - 1));

  typedef enum logic [1:0] {BufEmpty, BufFilling, BufFull} buf_state_e;

  buf_state_e                    buf_state_q [2];
  logic [ROW_LEN*DATA_WIDTH-1:0] buf_data_q  [2];
  logic                          buf_last_q  [2];
  logic [ColW-1:0]               col_q;
  logic [RowW-1:0]               row_q;
  logic                          wr_ptr_q;
  logic                          rd_ptr_q;
  logic                          sat_q;

  logic [4:0]             shift;
  logic signed [ExtW-1:0] acc_ext;
  logic signed [ExtW-1:0] rnd;
  logic signed [ExtW-1:0] sum;
  logic signed [ExtW-1:0] shifted;
  logic [DATA_WIDTH-1:0]  elem;
  logic                   sat;
  logic                   accept;
  logic                   release_row;
  logic                   row_done;

  // One extra bit of headroom so the rounding add cannot overflow.
  always_comb begin
    shift   = (cfg_shift > MaxShift) ? MaxShift : cfg_shift;
    acc_ext = {in_data[ACC_WIDTH-1], in_data};
    rnd     = '0;
    if (shift != 5'd0) begin
      rnd = ExtW'(1) << (shift - 5'd1);
    end
    sum     = acc_ext + rnd;
    shifted = sum >>> shift;
    sat     = 1'b0;
    if (shifted > SatMax) begin
      elem = SatMax[DATA_WIDTH-1:0];
      sat  = 1'b1;
    end else if (shifted < SatMin) begin
      elem = SatMin[DATA_WIDTH-1:0];
      sat  = 1'b1;
    end else begin
      elem = shifted[DATA_WIDTH-1:0];
    end
`ifdef MAC_REQUANT_RELU_EN
    if (elem[DATA_WIDTH-1]) begin
      elem = '0;
    end
`else
`endif
  end

  always_comb begin
    in_ready    = !((buf_state_q[0] == BufFull) && (buf_state_q[1] == BufFull));
    out_valid   = (buf_state_q[rd_ptr_q] == BufFull);
    out_data    = buf_data_q[rd_ptr_q];
    out_last    = out_valid && buf_last_q[rd_ptr_q];
    sat_flag    = sat_q;
    accept      = in_valid && in_ready;
    release_row = out_valid && out_ready;
    row_done    = accept && (col_q == ColW'(ROW_LEN - 1));
  end

  // Fill and release always target different buffers, so both updates may land together.
  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      for (int i = 0; i < 2; i++) begin
        buf_state_q[i] <= BufEmpty;
        buf_data_q[i]  <= '0;
        buf_last_q[i]  <= 1'b0;
      end
      col_q    <= '0;
      row_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      if (accept) begin
        buf_data_q[wr_ptr_q][int'(col_q)*DATA_WIDTH +: DATA_WIDTH] <= elem;
        buf_state_q[wr_ptr_q] <= row_done ? BufFull : BufFilling;
        if (sat) begin
          sat_q <= 1'b1;
        end
      end
      if (row_done) begin
        buf_last_q[wr_ptr_q] <= (row_q == RowW'(NUM_ROWS - 1));
        col_q                <= '0;
        row_q                <= (row_q == RowW'(NUM_ROWS - 1)) ? '0 : row_q + 1'b1;
        wr_ptr_q             <= ~wr_ptr_q;
      end else if (accept) begin
        col_q <= col_q + 1'b1;
      end
      if (release_row) begin
        buf_state_q[rd_ptr_q] <= BufEmpty;
        rd_ptr_q              <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: doc/mac_row_requant.md
# mac_row_requant

Downstream stage of the transformer MAC/linear layer. It takes the wide signed accumulator results (matmul plus bias) as a serial element stream and requantizes each element to DATA_WIDTH with a runtime right shift, round-half-up and saturation. It packs ROW_LEN results into one output row word and double-buffers rows so input can keep streaming while the consumer stalls. It marks the last row of each OUTPUT_SHAPE_1 × ROW_LEN matrix for the next op stage.

## Interface
- DATA_WIDTH, 8: output element width, signed.
- ACC_WIDTH, 24: input accumulator element width, signed.
- ROW_LEN, 16: elements per packed output row (OUTPUT_SHAPE_2 of the feeding MAC).
- NUM_ROWS, 8: rows per matrix (OUTPUT_SHAPE_1); drives out_last.
- clk_p  in  1  single clock, rising edge.
- rst_p  in  1  reset, synchronous, active-high.
- cfg_shift  in  5  right-shift amount, sampled per accepted element.
- in_data  in  ACC_WIDTH  signed accumulator element.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data.
- out_data  out  ROW_LEN*DATA_WIDTH  packed row; element 0 in bits [DATA_WIDTH-1:0].
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts row.
- out_last  out  1  qualifies out_data as row NUM_ROWS-1 of the matrix.
- sat_flag  out  1  sticky: some element saturated since reset.

## Operation
- Accept an element when in_valid && in_ready. Requantize it combinationally:
  - s = min(cfg_shift, ACC_WIDTH-1).
  - r = (in_data + (s ? 1<<(s-1) : 0)) >>> s, computed at ACC_WIDTH+1 bits.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Register the result into the fill buffer at slot col_cnt.
- Any saturation event sets sat_flag; only reset clears it.
- Two row buffers B0 and B1. Each has state EMPTY, FILLING or FULL, plus a stored last bit.
  - The write pointer selects the fill buffer; the read pointer selects the oldest FULL buffer.
  - col_cnt counts 0..ROW_LEN-1. When the element at ROW_LEN-1 is accepted:
    - the fill buffer goes FULL;
    - its last bit is set to (row_cnt == NUM_ROWS-1);
    - col_cnt goes to 0;
    - row_cnt increments, wrapping NUM_ROWS-1 to 0;
    - the write pointer toggles.
- in_ready = !(B0 FULL && B1 FULL). It has no combinational dependence on out_ready or in_valid.
- out_valid = (read buffer FULL). out_data and out_last come from the read buffer.
- On out_valid && out_ready, the read buffer goes EMPTY and the read pointer toggles.
- Simultaneous events:
  - A row completing in the same cycle as a row release both take effect.
  - in_ready is 1 next cycle, since at least one buffer is then not FULL.
- Once out_valid is asserted, out_data and out_last must stay stable until the handshake.

## Timing
- Latency: out_valid rises 1 cycle after the cycle the ROW_LEN-th element is accepted.
- Throughput: 1 element/cycle sustained when out_ready = 1, with no bubbles.
- With out_ready = 0:
  - exactly 2*ROW_LEN elements are accepted;
  - in_ready falls the cycle after the 2*ROW_LEN-th acceptance.
  - After out_ready returns, in_ready rises the cycle after the first row handshake.
- Reset values: in_ready = 1, out_valid = 0, out_last = 0, out_data = 0, sat_flag = 0. Both buffers EMPTY; col_cnt, row_cnt and both pointers = 0.
- Reset mid-operation: partial and full rows are discarded with no output. The first element after reset is column 0 of row 0.

## Configuration
- MAC_REQUANT_RELU_EN defined: after saturation, negative results are replaced by 0. sat_flag is unaffected by this clamp.
- Not defined: signed saturated results pass through unchanged.

## Test plan
All scenarios use DATA_WIDTH=8, ACC_WIDTH=24, ROW_LEN=4, NUM_ROWS=2.
- Rounding, cfg_shift=4: inputs 40, -40, 24, -24 -> one row out_data=0xFF02FE03, out_valid 1 cycle after the 4th accept, sat_flag=0.
- Saturation, cfg_shift=0: inputs 200, -300, 127, -128 -> out_data=0x807F807F, sat_flag=1.
  - With MAC_REQUANT_RELU_EN: out_data=0x007F007F.
- Shift clamp, cfg_shift=31: inputs 0x7FFFFF ×4 -> s=23, each result 1, out_data=0x01010101.
- Backpressure: out_ready=0, in_valid=1 for 12 cycles -> 8 elements accepted, in_ready=0 from cycle 9. Raise out_ready -> rows pop in order, in_ready returns the cycle after the first pop.
- Framing: 3 rows streamed -> out_last pattern 0, 1, 0.
- Reset mid-row: accept 2 elements, pulse rst_p for 1 cycle, then send 4 elements of value 16 with cfg_shift=4 -> a single row 0x01010101, out_last=0, nothing earlier emitted.
